ether_rx: RTL and testbench

Receive-side counterpart of the Ethernet transmit path. It consumes the RMII dibit stream from the PHY (crs_dv/rxd, already synchronised and glitch-filtered upstream), finds preamble and SFD, and filters on destination MAC. It then latches the source MAC and ethertype, strips the FCS and streams payload bytes to the consumer. A CRC-32 check runs inline, and a single done/ok strobe is issued per accepted frame.

---
 rtl/ether_rx_if.sv | 22 ++
 rtl/ether_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ether_rx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ether_rx_if.sv
// RMII receive-side bundle: dibit stream in from the PHY, payload bytes and
// per-frame status out to the consumer.
interface ether_rx_if;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [7:0]  axiod;
    logic        frame_done_out;
    logic        frame_ok_out;
    logic [47:0] src_mac_out;
    logic [15:0] ethertype_out;

    modport master (
        output axiiv, axiid,
        input  axiov, axiod, frame_done_out, frame_ok_out, src_mac_out, ethertype_out
    );

    modport slave (
        input  axiiv, axiid,
        output axiov, axiod, frame_done_out, frame_ok_out, src_mac_out, ethertype_out
    );
endinterface

// File: rtl/ether_rx.sv
// RMII Ethernet receiver: preamble/SFD hunt, destination MAC filter, header
// capture, FCS-stripping payload stream and inline CRC-32 check.
//
// state    | meaning
// IDLE     | waiting for carrier (only after carrier seen low since reset)
// PREAMBLE | counting 01 dibits, waiting for the 11 SFD dibit
// HEADER   | assembling dest/src/ethertype bytes, dest filtered at byte 5
// PAYLOAD  | streaming bytes through a 4-byte FCS-withholding delay line
// DROP     | ignoring the rest of a rejected frame until carrier drops
module ether_rx #(
    parameter logic [47:0] FPGA_MAC_ADDR       = 48'h69_2C_08_30_75_FD,
    parameter bit          ACCEPT_BROADCAST    = 1'b1,
    parameter int          MIN_PREAMBLE_DIBITS = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    ether_rx_if.slave  rx
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_HEADER   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_DROP     = 3'd4;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] BYTE_MAX    = 11'h7FF;
    localparam logic [5:0]  PRE_MIN     = 6'(MIN_PREAMBLE_DIBITS);

    logic [2:0]  state_q, state_d;
    logic        armed_q, armed_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [1:0]  phase_q, phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_sr_q, byte_sr_d;
    logic [63:0] hdr_q, hdr_d;
    logic [31:0] dly_q, dly_d;
    logic [2:0]  held_q, held_d;
    logic        axiov_q, axiov_d;
    logic [7:0]  axiod_q, axiod_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] eth_q, eth_d;

    logic [7:0]  byte_new;
    logic        byte_done;
    logic [31:0] crc_next;
    logic [10:0] byte_cnt_inc;
    logic [47:0] dest_full;
    logic        dest_ok;

    // Reflected CRC-32, earlier wire bit (d[0]) first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        byte_new     = {rx.axiid, byte_sr_q[7:2]};
        byte_done    = (phase_q == 2'd3);
        crc_next     = crc_dibit(crc_q, rx.axiid);
        byte_cnt_inc = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
        dest_full    = {hdr_q[39:0], byte_new};
        dest_ok      = (dest_full == FPGA_MAC_ADDR) ||
                       (ACCEPT_BROADCAST && (dest_full == 48'hFFFF_FFFF_FFFF));
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~rx.axiiv;
        pre_cnt_d  = pre_cnt_q;
        crc_d      = crc_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        byte_sr_d  = byte_sr_q;
        hdr_d      = hdr_q;
        dly_d      = dly_q;
        held_d     = held_q;
        axiov_d    = 1'b0;
        axiod_d    = axiod_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        src_mac_d  = src_mac_q;
        eth_d      = eth_q;

        case (state_q)
            S_IDLE: begin
                // armed_q keeps us from locking onto a frame already in flight at reset release
                if (armed_q && rx.axiiv) begin
                    if (rx.axiid == 2'b01) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 6'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!rx.axiiv) begin
                    state_d = S_IDLE;
                end else if (rx.axiid == 2'b01) begin
                    if (pre_cnt_q != 6'd63) pre_cnt_d = pre_cnt_q + 6'd1;
                end else if (rx.axiid == 2'b11 && pre_cnt_q >= PRE_MIN) begin
                    state_d    = S_HEADER;
                    crc_d      = 32'hFFFF_FFFF;
                    phase_d    = 2'd0;
                    byte_cnt_d = 11'd0;
                    held_d     = 3'd0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_HEADER: begin
                if (!rx.axiiv) begin
                    state_d = S_IDLE;
                    if (byte_cnt_q >= 11'd6) begin
                        done_d    = 1'b1;
                        src_mac_d = hdr_q[63:16];
                        eth_d     = hdr_q[15:0];
                    end
                end else begin
                    crc_d     = crc_next;
                    phase_d   = phase_q + 2'd1;
                    byte_sr_d = byte_new;
                    if (byte_done) begin
                        byte_cnt_d = byte_cnt_inc;
                        hdr_d      = {hdr_q[55:0], byte_new};
                        if (byte_cnt_q == 11'd5 && !dest_ok) state_d = S_DROP;
                        if (byte_cnt_q == 11'd13)            state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!rx.axiiv) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    ok_d      = (crc_q == CRC_RESIDUE) && (phase_q == 2'd0) &&
                                (held_q == 3'd4) && (byte_cnt_q >= 11'd18);
                    src_mac_d = hdr_q[63:16];
                    eth_d     = hdr_q[15:0];
                end else begin
                    crc_d     = crc_next;
                    phase_d   = phase_q + 2'd1;
                    byte_sr_d = byte_new;
                    if (byte_done) begin
                        byte_cnt_d = byte_cnt_inc;
                        dly_d      = {dly_q[23:0], byte_new};
                        // The last four bytes held at carrier drop are the FCS and are never emitted.
                        if (held_q == 3'd4) begin
                            axiov_d = 1'b1;
                            axiod_d = dly_q[31:24];
                        end else begin
                            held_d = held_q + 3'd1;
                        end
                    end
                end
            end
            S_DROP: begin
                if (!rx.axiiv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            pre_cnt_q  <= 6'd0;
            crc_q      <= 32'hFFFF_FFFF;
            phase_q    <= 2'd0;
            byte_cnt_q <= 11'd0;
            byte_sr_q  <= 8'd0;
            hdr_q      <= 64'd0;
            dly_q      <= 32'd0;
            held_q     <= 3'd0;
            axiov_q    <= 1'b0;
            axiod_q    <= 8'd0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            src_mac_q  <= 48'd0;
            eth_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            pre_cnt_q  <= pre_cnt_d;
            crc_q      <= crc_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            byte_sr_q  <= byte_sr_d;
            hdr_q      <= hdr_d;
            dly_q      <= dly_d;
            held_q     <= held_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            src_mac_q  <= src_mac_d;
            eth_q      <= eth_d;
        end
    end

    assign rx.axiov          = axiov_q;
    assign rx.axiod          = axiod_q;
    assign rx.frame_done_out = done_q;
    assign rx.frame_ok_out   = ok_q;
    assign rx.src_mac_out    = src_mac_q;
    assign rx.ethertype_out  = eth_q;

endmodule

// File: tb/tb_ether_rx.sv
// Scoreboard bench for ether_rx: stimulus pushes expected bytes and frame
// status into queues, a negedge monitor pops and compares DUT outputs.
module tb_ether_rx;

    localparam logic [47:0] MAC   = 48'h69_2C_08_30_75_FD;
    localparam logic [47:0] SRC   = 48'h88_66_5a_03_48_b0;
    localparam logic [47:0] SRC2  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h11_22_33_44_55_66;

    typedef struct {
        logic        ok;
        logic [47:0] src;
        logic [15:0] eth;
    } done_t;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    logic [7:0] frm[$];

    ether_rx_if bus();

    ether_rx #(
        .FPGA_MAC_ADDR(MAC),
        .ACCEPT_BROADCAST(1'b1),
        .MIN_PREAMBLE_DIBITS(16)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .rx(bus)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk_in) begin
        logic [7:0] e;
        done_t      d;
        if (bus.axiov) begin
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_axiov: got byte %02h expected no output", bus.axiod);
            end else begin
                e = exp_bytes.pop_front();
                chk("axiod", {56'd0, bus.axiod}, {56'd0, e});
            end
        end
        if (bus.frame_done_out) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done ok=%0d expected no done", bus.frame_ok_out);
            end else begin
                d = exp_done.pop_front();
                chk("frame_ok", {63'd0, bus.frame_ok_out}, {63'd0, d.ok});
                chk("bytes_pending_at_done", 64'(exp_bytes.size()), 64'd0);
                if (d.ok) begin
                    chk("src_mac", {16'd0, bus.src_mac_out}, {16'd0, d.src});
                    chk("ethertype", {48'd0, bus.ethertype_out}, {48'd0, d.eth});
                end
            end
        end
        if (bus.axiov && bus.frame_done_out) begin
            checks++;
            errors++;
            $display("FAIL axiov_with_done: got both high expected exclusive");
        end
    end

    function automatic logic [31:0] fcs_of_frm();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        foreach (frm[j]) begin
            b = frm[j];
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ ((c[0] ^ b[k]) ? 32'hEDB8_8320 : 32'h0);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] eth,
                         input int plen, input int mult, input int add);
        logic [31:0] f;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dest[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
        frm.push_back(eth[15:8]);
        frm.push_back(eth[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'((i * mult + add) & 8'hFF));
        f = fcs_of_frm();
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    task automatic push_payload(input int n, input int mult, input int add);
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'((i * mult + add) & 8'hFF));
    endtask

    task automatic push_done(input logic ok, input logic [47:0] src, input logic [15:0] eth);
        done_t d;
        d.ok  = ok;
        d.src = src;
        d.eth = eth;
        exp_done.push_back(d);
    endtask

    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge clk_in);
        #1;
        rst_n_in  = 1'b1;
        bus.axiiv = v;
        bus.axiid = d;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_axiov"}, {63'd0, bus.axiov}, 64'd0);
        chk({tag, "_axiod"}, {56'd0, bus.axiod}, 64'd0);
        chk({tag, "_done"}, {63'd0, bus.frame_done_out}, 64'd0);
        chk({tag, "_ok"}, {63'd0, bus.frame_ok_out}, 64'd0);
        chk({tag, "_src"}, {16'd0, bus.src_mac_out}, 64'd0);
        chk({tag, "_eth"}, {48'd0, bus.ethertype_out}, 64'd0);
    endtask

    // Sends preamble, SFD and n_dibits of frm; rst_idx < 0 means no reset pulse.
    task automatic send(input int pre_len, input int n_dibits, input int rst_idx);
        logic [7:0] b;
        for (int i = 0; i < pre_len; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int k = 0; k < n_dibits; k++) begin
            b = frm[k / 4];
            @(posedge clk_in);
            #1;
            if (rst_idx >= 0 && k == rst_idx + 1) check_outputs_zero("midreset");
            rst_n_in  = (k == rst_idx) ? 1'b0 : 1'b1;
            bus.axiiv = 1'b1;
            bus.axiid = b[(k % 4) * 2 +: 2];
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in  = 1'b0;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        repeat (3) @(posedge clk_in);
        #1;
        check_outputs_zero("reset");
        repeat (2) drive(1'b0, 2'b00);

        // Good frame
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        push_payload(46, 1, 0);
        push_done(1'b1, SRC, 16'h0800);
        send(28, frm.size() * 4, -1);

        // Payload byte 10 bit 2 flipped after FCS computed: 0x0A -> 0x0E
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        frm[14 + 10] = 8'h0E;
        for (int i = 0; i < 46; i++) exp_bytes.push_back((i == 10) ? 8'h0E : 8'(i));
        push_done(1'b0, SRC, 16'h0800);
        send(28, frm.size() * 4, -1);

        // Foreign dest: silent
        build(OTHER, SRC, 16'h0800, 46, 1, 0);
        send(28, frm.size() * 4, -1);

        // Broadcast dest accepted
        build(BCAST, SRC2, 16'h86DD, 46, 3, 5);
        push_payload(46, 3, 5);
        push_done(1'b1, SRC2, 16'h86DD);
        send(20, frm.size() * 4, -1);

        // Short preamble dropped, then a frame with exactly the minimum preamble
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        send(8, frm.size() * 4, -1);
        build(MAC, SRC, 16'h0806, 46, 1, 8'h40);
        push_payload(46, 1, 8'h40);
        push_done(1'b1, SRC, 16'h0806);
        send(16, frm.size() * 4, -1);

        // One dibit short: 49 bytes complete after header, 45 emitted
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        push_payload(45, 1, 0);
        push_done(1'b0, SRC, 16'h0800);
        send(20, frm.size() * 4 - 1, -1);

        // Carrier drops after 10 header bytes
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        push_done(1'b0, SRC, 16'h0800);
        send(20, 40, -1);

        // Minimum-length frame (header + FCS only) is good; one byte less is not
        build(MAC, SRC2, 16'h88B5, 0, 1, 0);
        push_done(1'b1, SRC2, 16'h88B5);
        send(20, 18 * 4, -1);
        push_done(1'b0, SRC2, 16'h88B5);
        send(20, 17 * 4, -1);

        // Reset during payload byte 20: payload 0..15 already emitted, no done
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        push_payload(16, 1, 0);
        send(20, frm.size() * 4, (14 + 20) * 4 + 1);
        build(MAC, SRC, 16'h0800, 46, 1, 0);
        push_payload(46, 1, 0);
        push_done(1'b1, SRC, 16'h0800);
        send(28, frm.size() * 4, -1);

        repeat (20) @(posedge clk_in);
        #1;
        chk("leftover_bytes", 64'(exp_bytes.size()), 64'd0);
        chk("leftover_done", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
